// File: rtl/mem_ctrl_arbiter_pkg.sv
// mem_ctrl_arbiter_pkg
//   Shared encodings for the memory-controller arbiter: FSM state type,
//   access-size codes, the default IO window selector and a helper that
//   turns a size code into a byte count.
package mem_ctrl_arbiter_pkg;

  typedef enum logic [1:0] {
    MC_IDLE   = 2'b00,
    MC_IF_RD  = 2'b01,
    MC_MEM_RD = 2'b10,
    MC_MEM_WR = 2'b11
  } mc_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // addr[17:16] value that selects the IO window
  localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

  // Byte count of an access; the unused code 11 behaves as a word.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      SIZE_B:  size_to_len = 3'd1;
      SIZE_H:  size_to_len = 3'd2;
      default: size_to_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// mem_ctrl_arbiter
//   Owns the byte-wide RAM port and shares it between instruction fetch
//   (always 4 bytes) and MEM-stage loads/stores (1/2/4 bytes), moving one
//   byte per cycle. MEM has priority; arbitration only happens in IDLE.
//
// Ports
//   clk_in, rst_in (sync, active-high), rdy_in (low = freeze everything)
//   if_req_in / if_addr_in / if_abort_in      fetch request, address, flush
//   if_done_out / if_inst_out                 fetch done pulse, fetched word
//   mem_req_in / mem_we_in / mem_size_in      MEM request, store flag, size
//   mem_addr_in / mem_wdata_in                MEM address, store data
//   mem_done_out / mem_rdata_out              MEM done pulse, load data
//   mem_access_out                            MEM is using / wants the port
//   ram_din_in / ram_dout_out                 RAM read / write byte
//   ram_a_out / ram_wr_out                    RAM address / write strobe
//   io_buffer_full_in                         UART buffer full
//
// Build option
//   MC_IO_STALL_EN : hold IO-window stores in IDLE while io_buffer_full_in
//                    is high, and insert one dead IDLE cycle after each IO
//                    write. Undefined: io_buffer_full_in is ignored.
//
// state     | meaning
// ----------+---------------------------------------------------------
// MC_IDLE   | port free; arbitrate (MEM beats IF)
// MC_IF_RD  | 4-byte fetch in progress; abortable
// MC_MEM_RD | MEM load in progress (1/2/4 bytes)
// MC_MEM_WR | MEM store in progress (1/2/4 bytes)
module mem_ctrl_arbiter
  import mem_ctrl_arbiter_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = IO_HI_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              if_abort_in,
  output logic              if_done_out,
  output logic [31:0]       if_inst_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [1:0]        mem_size_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  output logic              mem_done_out,
  output logic [31:0]       mem_rdata_out,
  output logic              mem_access_out,
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [ADDR_W-1:0] ram_a_out,
  output logic              ram_wr_out,
  input  logic              io_buffer_full_in
);

  mc_state_e         state_q, state_d;
  // cnt_q holds the index of the edge about to happen, counted from the
  // accept edge (E0). It addresses byte cnt and samples byte cnt-2.
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              wr_q, wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic              io_block;
  logic              dead_cycle;
  logic              mem_ok;
  logic              if_ok;
  logic [1:0]        byte_idx;
  logic [31:0]       rbuf_merged;
  logic [ADDR_W-1:0] addr_k;

`ifdef MC_IO_STALL_EN
  logic io_last_q, io_last_d;
  logic io_dead_q, io_dead_d;

  assign io_block   = mem_we_in && (mem_addr_in[17:16] == IO_HI) && io_buffer_full_in;
  assign dead_cycle = io_dead_q;
`else
  logic [2:0] unused_io;

  assign unused_io  = {io_buffer_full_in, IO_HI};
  assign io_block   = 1'b0;
  assign dead_cycle = 1'b0;
`endif

  // A requester whose done pulse is high this cycle is ignored, so a
  // request is never serviced twice.
  assign mem_ok = mem_req_in && !mem_done_q && !io_block && !dead_cycle;
  assign if_ok  = if_req_in && !if_done_q && !if_abort_in && !dead_cycle;

  assign byte_idx = cnt_q[1:0] - 2'd2;
  assign addr_k   = base_q + ADDR_W'(cnt_q);

  always_comb begin
    rbuf_merged = rbuf_q;
    rbuf_merged[{byte_idx, 3'b000} +: 8] = ram_din_in;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    wr_d        = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
`ifdef MC_IO_STALL_EN
    io_last_d   = io_last_q;
    io_dead_d   = 1'b0;
`endif

    case (state_q)
      MC_IDLE: begin
`ifdef MC_IO_STALL_EN
        io_dead_d = mem_done_q && io_last_q;
`endif
        if (mem_ok) begin
          base_d  = mem_addr_in;
          len_d   = size_to_len(mem_size_in);
          cnt_d   = 3'd1;
          ram_a_d = mem_addr_in;
          if (mem_we_in) begin
            state_d    = MC_MEM_WR;
            wdata_d    = mem_wdata_in;
            ram_dout_d = mem_wdata_in[7:0];
            wr_d       = 1'b1;
          end else begin
            state_d = MC_MEM_RD;
            rbuf_d  = '0;
          end
        end else if (if_ok) begin
          state_d = MC_IF_RD;
          base_d  = if_addr_in;
          len_d   = 3'd4;
          cnt_d   = 3'd1;
          ram_a_d = if_addr_in;
          rbuf_d  = '0;
        end
      end

      MC_IF_RD, MC_MEM_RD: begin
        if (state_q == MC_IF_RD && if_abort_in) begin
          state_d = MC_IDLE;
          cnt_d   = '0;
          ram_a_d = '0;
        end else begin
          if (cnt_q >= 3'd2) rbuf_d = rbuf_merged;
          ram_a_d = (cnt_q < len_q) ? addr_k : '0;
          if (cnt_q == len_q + 3'd1) begin
            state_d = MC_IDLE;
            cnt_d   = '0;
            if (state_q == MC_IF_RD) begin
              if_done_d = 1'b1;
              if_inst_d = rbuf_merged;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = rbuf_merged;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      MC_MEM_WR: begin
        if (cnt_q < len_q) begin
          ram_a_d    = addr_k;
          ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          wr_d       = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end else begin
          state_d    = MC_IDLE;
          cnt_d      = '0;
          ram_a_d    = '0;
          mem_done_d = 1'b1;
`ifdef MC_IO_STALL_EN
          io_last_d  = (base_q[17:16] == IO_HI);
`endif
        end
      end

      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= MC_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      wr_q        <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
`ifdef MC_IO_STALL_EN
      io_last_q   <= 1'b0;
      io_dead_q   <= 1'b0;
`endif
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      wr_q        <= wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef MC_IO_STALL_EN
      io_last_q   <= io_last_d;
      io_dead_q   <= io_dead_d;
`endif
    end
  end

  assign if_done_out    = if_done_q;
  assign if_inst_out    = if_inst_q;
  assign mem_done_out   = mem_done_q;
  assign mem_rdata_out  = mem_rdata_q;
  assign ram_a_out      = ram_a_q;
  assign ram_dout_out   = ram_dout_q;
  // The strobe is gated so a frozen cycle never writes the RAM.
  assign ram_wr_out     = wr_q && rdy_in;
  assign mem_access_out = mem_req_in || (state_q == MC_MEM_RD) || (state_q == MC_MEM_WR);

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
module tb_mem_ctrl_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_abort_in;
  logic        if_done_out;
  logic [31:0] if_inst_out;
  logic        mem_req_in;
  logic        mem_we_in;
  logic [1:0]  mem_size_in;
  logic [31:0] mem_addr_in;
  logic [31:0] mem_wdata_in;
  logic        mem_done_out;
  logic [31:0] mem_rdata_out;
  logic        mem_access_out;
  logic [7:0]  ram_din_in;
  logic [7:0]  ram_dout_out;
  logic [31:0] ram_a_out;
  logic        ram_wr_out;
  logic        io_buffer_full_in;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] ram [int unsigned];

  always #5 clk_in = ~clk_in;

  mem_ctrl_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .if_req_in         (if_req_in),
    .if_addr_in        (if_addr_in),
    .if_abort_in       (if_abort_in),
    .if_done_out       (if_done_out),
    .if_inst_out       (if_inst_out),
    .mem_req_in        (mem_req_in),
    .mem_we_in         (mem_we_in),
    .mem_size_in       (mem_size_in),
    .mem_addr_in       (mem_addr_in),
    .mem_wdata_in      (mem_wdata_in),
    .mem_done_out      (mem_done_out),
    .mem_rdata_out     (mem_rdata_out),
    .mem_access_out    (mem_access_out),
    .ram_din_in        (ram_din_in),
    .ram_dout_out      (ram_dout_out),
    .ram_a_out         (ram_a_out),
    .ram_wr_out        (ram_wr_out),
    .io_buffer_full_in (io_buffer_full_in)
  );

  function automatic logic [7:0] rd(input logic [31:0] a);
    rd = ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  // RAM model: one register stage after the DUT's registered address gives
  // the two-edge latency; it sits in the same frozen domain as the DUT.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      ram_din_in <= rd(ram_a_out);
      if (ram_wr_out) ram[ram_a_out] = ram_dout_out;
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    if_req_in = 1'b0; if_addr_in = '0; if_abort_in = 1'b0;
    mem_req_in = 1'b0; mem_we_in = 1'b0; mem_size_in = 2'b00;
    mem_addr_in = '0; mem_wdata_in = '0; io_buffer_full_in = 1'b0;
    ram_din_in = 8'h00;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h2000] = 8'h11; ram[32'h2001] = 8'h22; ram[32'h2002] = 8'h33; ram[32'h2003] = 8'h44;

    step(); step();
    rst_in = 1'b0;
    chk("rst ram_a", ram_a_out, 32'h0);
    chk("rst dout", {24'h0, ram_dout_out}, 32'h0);
    chk("rst wr", {31'h0, ram_wr_out}, 32'h0);
    chk("rst dones", {30'h0, if_done_out, mem_done_out}, 32'h0);
    chk("rst inst", if_inst_out, 32'h0);
    chk("rst rdata", mem_rdata_out, 32'h0);
    chk("rst access", {31'h0, mem_access_out}, 32'h0);

    // 1: plain fetch
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1 addr", ram_a_out, 32'h1000 + k);
      chk("t1 early done", {31'h0, if_done_out}, 32'h0);
    end
    step();
    chk("t1 E4 done", {31'h0, if_done_out}, 32'h0);
    step();
    chk("t1 E5 done", {31'h0, if_done_out}, 32'h1);
    chk("t1 inst", if_inst_out, 32'h00000513);
    if_req_in = 1'b0;
    step();
    chk("t1 pulse", {31'h0, if_done_out}, 32'h0);
    chk("t1 hold", if_inst_out, 32'h00000513);

    // 2: MEM beats IF
    mem_req_in = 1'b1; mem_we_in = 1'b0; mem_size_in = 2'b10; mem_addr_in = 32'h2000;
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    #1;
    chk("t2 access pre", {31'h0, mem_access_out}, 32'h1);
    step();
    chk("t2 addr E0", ram_a_out, 32'h2000);
    for (int k = 1; k < 5; k++) begin
      step();
      chk("t2 access", {31'h0, mem_access_out}, 32'h1);
      chk("t2 no done", {30'h0, if_done_out, mem_done_out}, 32'h0);
    end
    step();
    chk("t2 mem done", {31'h0, mem_done_out}, 32'h1);
    chk("t2 rdata", mem_rdata_out, 32'h44332211);
    mem_req_in = 1'b0;
    #1;
    chk("t2 access idle", {31'h0, mem_access_out}, 32'h0);
    step();
    chk("t2 if accept", ram_a_out, 32'h1000);
    chk("t2 done drop", {31'h0, mem_done_out}, 32'h0);
    chk("t2 access if", {31'h0, mem_access_out}, 32'h0);
    for (int k = 0; k < 5; k++) step();
    chk("t2 if done", {31'h0, if_done_out}, 32'h1);
    chk("t2 inst", if_inst_out, 32'h00000513);
    if_req_in = 1'b0;
    step();

    // 3: half store across a 64K boundary
    mem_req_in = 1'b1; mem_we_in = 1'b1; mem_size_in = 2'b01;
    mem_addr_in = 32'h0003FFFF; mem_wdata_in = 32'h0000BEEF;
    step();
    chk("t3 E0 a", ram_a_out, 32'h0003FFFF);
    chk("t3 E0 d", {24'h0, ram_dout_out}, 32'hEF);
    chk("t3 E0 wr", {31'h0, ram_wr_out}, 32'h1);
    step();
    chk("t3 E1 a", ram_a_out, 32'h00040000);
    chk("t3 E1 d", {24'h0, ram_dout_out}, 32'hBE);
    chk("t3 E1 wr", {31'h0, ram_wr_out}, 32'h1);
    step();
    chk("t3 E2 wr", {31'h0, ram_wr_out}, 32'h0);
    chk("t3 E2 a", ram_a_out, 32'h0);
    chk("t3 E2 done", {31'h0, mem_done_out}, 32'h1);
    mem_req_in = 1'b0;
    chk("t3 ram lo", {24'h0, rd(32'h0003FFFF)}, 32'hEF);
    chk("t3 ram hi", {24'h0, rd(32'h00040000)}, 32'hBE);
    step();

    // 4: abort on the completing edge, abort blocks accept in IDLE
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    for (int k = 0; k < 5; k++) step();
    if_abort_in = 1'b1;
    step();
    chk("t4 no done", {31'h0, if_done_out}, 32'h0);
    chk("t4 a zero", ram_a_out, 32'h0);
    if_addr_in = 32'h2000;
    step();
    chk("t4 idle blocked", ram_a_out, 32'h0);
    if_abort_in = 1'b0;
    step();
    chk("t4 refetch", ram_a_out, 32'h2000);
    for (int k = 0; k < 5; k++) step();
    chk("t4 done", {31'h0, if_done_out}, 32'h1);
    chk("t4 inst", if_inst_out, 32'h44332211);
    if_req_in = 1'b0;
    step();

    // byte load: zero-extended, done at E2
    mem_req_in = 1'b1; mem_we_in = 1'b0; mem_size_in = 2'b00; mem_addr_in = 32'h2003;
    step(); step();
    chk("byte E1 done", {31'h0, mem_done_out}, 32'h0);
    step();
    chk("byte E2 done", {31'h0, mem_done_out}, 32'h1);
    chk("byte rdata", mem_rdata_out, 32'h00000044);
    mem_req_in = 1'b0;
    step();

    // 5a: freeze during a word store
    mem_req_in = 1'b1; mem_we_in = 1'b1; mem_size_in = 2'b10;
    mem_addr_in = 32'h5000; mem_wdata_in = 32'hCAFEF00D;
    step();
    rdy_in = 1'b0;
    #1;
    chk("t5 wr gated", {31'h0, ram_wr_out}, 32'h0);
    step(); step();
    chk("t5 st frozen a", ram_a_out, 32'h5000);
    chk("t5 st wr", {31'h0, ram_wr_out}, 32'h0);
    rdy_in = 1'b1;
    #1;
    chk("t5 wr resume", {31'h0, ram_wr_out}, 32'h1);
    for (int k = 0; k < 4; k++) step();
    chk("t5 st done", {31'h0, mem_done_out}, 32'h1);
    mem_req_in = 1'b0;
    chk("t5 st ram", {rd(32'h5003), rd(32'h5002), rd(32'h5001), rd(32'h5000)}, 32'hCAFEF00D);
    step();

    // 5b: freeze during a word load
    mem_req_in = 1'b1; mem_we_in = 1'b0; mem_size_in = 2'b10; mem_addr_in = 32'h2000;
    step(); step(); step();
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5 ld frozen a", ram_a_out, 32'h2002);
      chk("t5 ld no done", {31'h0, mem_done_out}, 32'h0);
    end
    rdy_in = 1'b1;
    step(); step();
    chk("t5 ld early", {31'h0, mem_done_out}, 32'h0);
    step();
    chk("t5 ld done", {31'h0, mem_done_out}, 32'h1);
    chk("t5 ld rdata", mem_rdata_out, 32'h44332211);
    mem_req_in = 1'b0;
    step();

    // 6: IO store with the UART buffer full
    mem_req_in = 1'b1; mem_we_in = 1'b1; mem_size_in = 2'b00;
    mem_addr_in = 32'h00030000; mem_wdata_in = 32'h00000041;
    io_buffer_full_in = 1'b1;
`ifdef MC_IO_STALL_EN
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t6 stalled wr", {31'h0, ram_wr_out}, 32'h0);
    end
    io_buffer_full_in = 1'b0;
`endif
    step();
    chk("t6 wr", {31'h0, ram_wr_out}, 32'h1);
    chk("t6 a", ram_a_out, 32'h00030000);
    chk("t6 d", {24'h0, ram_dout_out}, 32'h41);
    step();
    chk("t6 done", {31'h0, mem_done_out}, 32'h1);
    mem_req_in = 1'b0;
    io_buffer_full_in = 1'b0;
    chk("t6 ram", {24'h0, rd(32'h00030000)}, 32'h41);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
